// File: rtl/fetch_pkg.sv
// Shared encodings and state type for the fetch sequencing controller.
package fetch_pkg;

  localparam logic [3:0] PL_SEQ   = 4'b0000;
  localparam logic [3:0] PL_V0    = 4'b0001;
  localparam logic [3:0] PL_V1    = 4'b0010;
  localparam logic [3:0] PL_V2    = 4'b0011;
  localparam logic [3:0] PL_V3    = 4'b0100;
  localparam logic [3:0] PL_IVT   = 4'b0101;
  localparam logic [3:0] PL_RET   = 4'b0110;
  localparam logic [3:0] PL_CALL  = 4'b0111;
  localparam logic [3:0] PL_RESET = 4'b1000;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_P1   = 2'b01;
  localparam logic [1:0] SEL_P2   = 2'b10;

  // Drain counter width; covers DRAIN_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RST_LOAD,
    RUN,
    INT_DRAIN,
    INT_JUMP
  } state_e;

  // Exception causes 0..3 land on vectors PL_V0..PL_V3.
  function automatic logic [3:0] exc_vector(input logic [1:0] code);
    return {2'b00, code} + 4'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/control bundle between the fetch sequencer (master) and the fetch/request side (slave).
interface fetch_ctrl_if;

  logic       stall;
  logic       inst_long;
  logic       exc_valid;
  logic [1:0] exc_code;
  logic       call_valid;
  logic       ret_valid;
  logic       rti_valid;
  logic       int_req;
  logic [2:0] int_index;

  logic [3:0] pc_place;
  logic [1:0] pc_select;
  logic       save_pc;
  logic       int_ack;
  logic [2:0] int_index_q;
  logic       in_service;

  modport master (
    input  stall, inst_long, exc_valid, exc_code, call_valid, ret_valid, rti_valid,
           int_req, int_index,
    output pc_place, pc_select, save_pc, int_ack, int_index_q, in_service
  );

  modport slave (
    output stall, inst_long, exc_valid, exc_code, call_valid, ret_valid, rti_valid,
           int_req, int_index,
    input  pc_place, pc_select, save_pc, int_ack, int_index_q, in_service
  );

endinterface

// File: rtl/fetch_ctrl_prio.sv
// Combinational PC-source priority encoder used while the sequencer is in RUN.
module fetch_ctrl_prio
  import fetch_pkg::*;
(
  input  logic       exc_valid,
  input  logic [1:0] exc_code,
  input  logic       rti_valid,
  input  logic       call_valid,
  input  logic       ret_valid,
  input  logic       int_req,
  input  logic       int_ok,
  input  logic       stall,
  input  logic       inst_long,
  output logic [3:0] pc_place,
  output logic [1:0] pc_select,
  output logic       take_int,
  output logic       take_rti
);

  always_comb begin
    pc_place  = PL_SEQ;
    pc_select = SEL_HOLD;
    take_int  = 1'b0;
    take_rti  = 1'b0;
    if (exc_valid) begin
      pc_place = exc_vector(exc_code);
    end else if (rti_valid) begin
      pc_place = PL_RET;
      take_rti = 1'b1;
    end else if (call_valid) begin
      pc_place = PL_CALL;
    end else if (ret_valid) begin
      pc_place = PL_RET;
    end else if (int_req && int_ok) begin
      take_int = 1'b1;
    end else if (!stall) begin
      pc_select = inst_long ? SEL_P2 : SEL_P1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: reset vector, redirects, and multi-cycle interrupt entry.
// Define FETCH_CTRL_NESTED_INT_EN for nested interrupts up to MAX_NEST deep.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MAX_NEST     = 3
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || MAX_NEST < 1) begin : g_bad_params
    $error("fetch_ctrl: DRAIN_CYCLES must be 1..15 and MAX_NEST at least 1");
  end

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;

  logic       svc_set, svc_clr;
  logic       int_ok, in_service;
  logic [3:0] prio_place;
  logic [1:0] prio_select;
  logic       prio_take_int, prio_take_rti;

  logic [3:0] place;
  logic [1:0] select;
  logic       save_pc, int_ack;

  fetch_ctrl_prio u_prio (
    .exc_valid  (bus.exc_valid),
    .exc_code   (bus.exc_code),
    .rti_valid  (bus.rti_valid),
    .call_valid (bus.call_valid),
    .ret_valid  (bus.ret_valid),
    .int_req    (bus.int_req),
    .int_ok     (int_ok),
    .stall      (bus.stall),
    .inst_long  (bus.inst_long),
    .pc_place   (prio_place),
    .pc_select  (prio_select),
    .take_int   (prio_take_int),
    .take_rti   (prio_take_rti)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_LOAD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    place   = PL_SEQ;
    select  = SEL_HOLD;
    save_pc = 1'b0;
    int_ack = 1'b0;
    svc_set = 1'b0;
    svc_clr = 1'b0;
    unique case (state_q)
      RST_LOAD: begin
        place   = PL_RESET;
        state_d = RUN;
      end
      RUN: begin
        place   = prio_place;
        select  = prio_select;
        svc_clr = prio_take_rti;
        if (prio_take_int) begin
          idx_d   = bus.int_index;
          save_pc = 1'b1;
          cnt_d   = CNT_RELOAD;
          state_d = INT_DRAIN;
        end
      end
      INT_DRAIN: begin
        if (bus.exc_valid) begin
          // Abort entry; the level request is simply re-taken from RUN.
          place   = exc_vector(bus.exc_code);
          state_d = RUN;
        end else if (bus.call_valid || bus.ret_valid) begin
          // Redirect changes the PC to be saved, so save again and restart the drain.
          place   = bus.call_valid ? PL_CALL : PL_RET;
          save_pc = 1'b1;
          cnt_d   = CNT_RELOAD;
        end else if (cnt_q == '0) begin
          state_d = INT_JUMP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      INT_JUMP: begin
        state_d = RUN;
        if (bus.exc_valid) begin
          place = exc_vector(bus.exc_code);
        end else begin
          place   = PL_IVT;
          int_ack = 1'b1;
          svc_set = 1'b1;
        end
      end
      default: state_d = RST_LOAD;
    endcase
    // Controls read zero for as long as reset is held, not just from the next edge.
    if (!rst_n) begin
      place   = PL_SEQ;
      select  = SEL_HOLD;
      save_pc = 1'b0;
      int_ack = 1'b0;
    end
  end

`ifdef FETCH_CTRL_NESTED_INT_EN
  localparam int unsigned          DEPTH_W   = $clog2(MAX_NEST + 1);
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX = DEPTH_W'(MAX_NEST);

  logic [DEPTH_W-1:0] depth_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q <= '0;
    end else if (svc_set) begin
      depth_q <= depth_q + DEPTH_W'(1);
    end else if (svc_clr && depth_q != '0) begin
      depth_q <= depth_q - DEPTH_W'(1);
    end
  end

  assign in_service = (depth_q != '0);
  assign int_ok     = (depth_q < DEPTH_MAX);
`else
  logic svc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      svc_q <= 1'b0;
    end else if (svc_set) begin
      svc_q <= 1'b1;
    end else if (svc_clr) begin
      svc_q <= 1'b0;
    end
  end

  assign in_service = svc_q;
  assign int_ok     = !svc_q;
`endif

  assign bus.pc_place    = place;
  assign bus.pc_select   = select;
  assign bus.save_pc     = save_pc;
  assign bus.int_ack     = int_ack;
  assign bus.int_index_q = idx_q;
  assign bus.in_service  = in_service;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl (default single-level build, DRAIN_CYCLES=3).
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .DRAIN_CYCLES (3),
    .MAX_NEST     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.stall      = 1'b0;
    bus.inst_long  = 1'b0;
    bus.exc_valid  = 1'b0;
    bus.exc_code   = 2'd0;
    bus.call_valid = 1'b0;
    bus.ret_valid  = 1'b0;
    bus.rti_valid  = 1'b0;
    bus.int_req    = 1'b0;
    bus.int_index  = 3'd0;
  endtask

  // Compares {pc_place, pc_select, save_pc, int_ack, in_service} in one shot.
  task automatic expect_out(input string tag, input logic [3:0] place, input logic [1:0] sel,
                            input logic save, input logic ack, input logic svc);
    logic [8:0] obs, exp;
    obs = {bus.pc_place, bus.pc_select, bus.save_pc, bus.int_ack, bus.in_service};
    exp = {place, sel, save, ack, svc};
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed place/sel/save/ack/svc=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_idx(input string tag, input logic [2:0] idx);
    n_cmp++;
    assert (bus.int_index_q === idx) else begin
      n_bad++;
      $error("FAIL %s: observed int_index_q=%0d expected %0d", tag, bus.int_index_q, idx);
    end
  endtask

  // Next cycle: inputs change on the falling edge, outputs sampled 1ns later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    idle();
    repeat (2) step();
    #1 expect_out("reset", 4'b0000, 2'b00, 0, 0, 0);
    expect_idx("reset_idx", 3'd0);

    step(); rst_n = 1'b1;
    #1 expect_out("rst_load", 4'b1000, 2'b00, 0, 0, 0);

    step(); #1 expect_out("seq_p1", 4'b0000, 2'b01, 0, 0, 0);
    step(); bus.inst_long = 1'b1;
    #1 expect_out("seq_p2", 4'b0000, 2'b10, 0, 0, 0);
    step(); bus.stall = 1'b1;
    #1 expect_out("stall", 4'b0000, 2'b00, 0, 0, 0);

    step(); bus.stall = 1'b0; bus.inst_long = 1'b0; bus.int_req = 1'b1; bus.int_index = 3'd5;
    #1 expect_out("int_accept", 4'b0000, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); bus.stall = (i == 0);
      #1 expect_out("drain", 4'b0000, 2'b00, 0, 0, 0);
    end
    step(); bus.stall = 1'b0;
    #1 expect_out("int_jump", 4'b0101, 2'b00, 0, 1, 0);
    expect_idx("int_jump_idx", 3'd5);

    step(); #1 expect_out("masked", 4'b0000, 2'b01, 0, 0, 1);
    step(); bus.rti_valid = 1'b1;
    #1 expect_out("rti", 4'b0110, 2'b00, 0, 0, 1);
    step(); bus.rti_valid = 1'b0; bus.int_index = 3'd2;
    #1 expect_out("retake", 4'b0000, 2'b00, 1, 0, 0);

    step(); #1 expect_out("drain_a", 4'b0000, 2'b00, 0, 0, 0);
    step(); bus.exc_valid = 1'b1; bus.exc_code = 2'd2;
    #1 expect_out("exc_abort", 4'b0011, 2'b00, 0, 0, 0);
    step(); bus.exc_valid = 1'b0;
    #1 expect_out("retake2", 4'b0000, 2'b00, 1, 0, 0);

    step(); bus.int_req = 1'b0; bus.call_valid = 1'b1; bus.ret_valid = 1'b1; bus.stall = 1'b1;
    #1 expect_out("drain_call", 4'b0111, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); bus.call_valid = 1'b0; bus.ret_valid = 1'b0; bus.stall = 1'b0;
      #1 expect_out("drain_reload", 4'b0000, 2'b00, 0, 0, 0);
    end
    step(); #1 expect_out("jump2", 4'b0101, 2'b00, 0, 1, 0);
    expect_idx("jump2_idx", 3'd2);

    step(); bus.call_valid = 1'b1; bus.ret_valid = 1'b1; bus.stall = 1'b1;
    #1 expect_out("run_call_stall", 4'b0111, 2'b00, 0, 0, 1);
    step(); bus.call_valid = 1'b0; bus.ret_valid = 1'b0; bus.stall = 1'b0;
    bus.exc_valid = 1'b1; bus.exc_code = 2'd3; bus.rti_valid = 1'b1;
    #1 expect_out("exc_over_rti", 4'b0100, 2'b00, 0, 0, 1);
    step(); bus.exc_valid = 1'b0;
    #1 expect_out("rti2", 4'b0110, 2'b00, 0, 0, 1);
    step(); bus.rti_valid = 1'b0;
    #1 expect_out("svc_clear", 4'b0000, 2'b01, 0, 0, 0);

    step(); bus.int_req = 1'b1; bus.int_index = 3'd3;
    #1 expect_out("accept3", 4'b0000, 2'b00, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(); bus.int_req = 1'b0;
      #1 expect_out("drain3", 4'b0000, 2'b00, 0, 0, 0);
    end
    step(); bus.exc_valid = 1'b1; bus.exc_code = 2'd0;
    #1 expect_out("exc_in_jump", 4'b0001, 2'b00, 0, 0, 0);
    step(); bus.exc_valid = 1'b0; bus.int_req = 1'b1; bus.int_index = 3'd7;
    #1 expect_out("jump_preempted", 4'b0000, 2'b00, 1, 0, 0);
    step(); bus.int_req = 1'b0;
    #1 expect_out("drain7", 4'b0000, 2'b00, 0, 0, 0);
    expect_idx("drain7_idx", 3'd7);

    step(); rst_n = 1'b0;
    #1 expect_out("async_rst", 4'b0000, 2'b00, 0, 0, 0);
    expect_idx("async_rst_idx", 3'd0);
    step();
    step(); rst_n = 1'b1;
    #1 expect_out("rst_load2", 4'b1000, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(); #1 expect_out("post_rst", 4'b0000, 2'b01, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of sequence, expected completion before 100000ns");
    $fatal(1, "watchdog expired");
  end

endmodule
